bcd_7seg_decoder: RTL and testbench
===================================

BCD_7SEG_DECODER -- requirements
Module: bcd_7seg_decoder

Interface
REQ-001 SHALL have parameter ACTIVE_LOW, default 1, meaning 1 = segment lit when output is 0 (DE-series HEX), 0 = lit when 1.
REQ-002 SHALL have parameter HEX_MODE, default 0, meaning 0 = codes 10-15 blank, 1 = codes 10-15 show A,b,C,d,E,F.
REQ-003 SHALL have port CLOCK_50  input  1  sole clock; all state on its rising edge.
REQ-004 SHALL have port KEY0  input  1  reset, synchronous, active-low.
REQ-005 SHALL have ports A, B, C, D  input  1 each  BCD code, A = MSB (bit 3), D = LSB (bit 0).
REQ-006 SHALL have port en  input  1  1 = sample and decode the code this cycle, 0 = hold outputs.
REQ-007 SHALL have port blank  input  1  1 = all segments off.
REQ-008 SHALL have port lt  input  1  lamp test, 1 = all segments on.
REQ-009 SHALL have port rbi  input  1  ripple-blank in, 1 = suppress a zero digit.
REQ-010 SHALL have ports a, b, c, d, e, f, g  output  1 each  registered segment drives in standard order (a top, then clockwise, g middle).
REQ-011 SHALL have port rbo  output  1  ripple-blank out, registered.

Function
REQ-012 SHALL register all outputs, with 1-cycle latency from a sampled input to the outputs.
REQ-013 SHALL decode lit segments for codes 0-9 as: 0=abcdef, 1=bc, 2=abdeg, 3=abcdg, 4=bcfg, 5=acdfg, 6=acdefg, 7=abc, 8=abcdefg, 9=abcdfg.
REQ-014 SHALL, when HEX_MODE=1, decode codes 10-15 as: A=abcefg, b=cdefg, C=adef, d=bcdeg, E=adefg, F=aefg; when HEX_MODE=0, codes 10-15 SHALL light no segment.
REQ-015 SHALL, when en=1, resolve the next state with priority lt > blank > (rbi AND code==0 -> blank) > decode.
REQ-016 SHALL, when en=0, hold a-g and rbo unchanged, regardless of lt, blank and rbi.
REQ-017 SHALL set rbo to 1 exactly when en=1, rbi=1, code==0, lt=0 and blank=0; otherwise, on any enabled cycle, rbo SHALL be 0.
REQ-018 SHALL apply polarity last: physical output = lit XOR ACTIVE_LOW.
REQ-019 SHALL treat A-D as any 4-bit value; there is no illegal-input state and no X propagation.

Reset
REQ-020 SHALL, when KEY0=0 at a rising edge, drive all segments off (a-g = 1 for ACTIVE_LOW=1) and rbo=0, overriding en, lt and blank.
REQ-021 SHALL, when KEY0 returns high, resume normal operation with the first enabled sample taking effect on the next edge; KEY0 has no asynchronous path.

Structure
REQ-022 SHALL take the 7-bit segment pattern constants (SEG_0..SEG_F, SEG_OFF, SEG_ALL, in active-high abcdefg order) from a shared package, bcd_7seg_pkg.
REQ-023 SHALL implement the combinational code-to-pattern table in one sub-module, bcd_7seg_lut; the top level holds only priority logic, polarity and registers.

Verification
REQ-024 Bench SHALL check: KEY0=0 for 2 cycles with code 8, lt=1 -> a-g=1111111 and rbo=0 at every edge during reset.
REQ-025 Bench SHALL check: ACTIVE_LOW=1, en=1, codes 0..9 in successive cycles -> one cycle later, for example code 0 gives gfedcba=1000000 and code 7 gives 1111000.
REQ-026 Bench SHALL check: HEX_MODE=0 with code 12 -> all off; HEX_MODE=1 with code 12 -> C pattern adef lit.
REQ-027 Bench SHALL check: code 5 latched, then en=0 and code changed to 3 -> outputs remain the 5 pattern until en=1.
REQ-028 Bench SHALL check: rbi=1 with code 0 -> blank and rbo=1; rbi=1 with code 4 -> 4 shown and rbo=0; lt=1 with blank=1 -> all lit.

Source files
------------

// File: rtl/bcd_7seg_pkg.sv
// rtl/bcd_7seg_pkg.sv - shared seven-segment pattern constants and polarity helper
package bcd_7seg_pkg;

  // Active-high segment pattern, bit 6 = a down to bit 0 = g
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0   = 7'b1111110;
  localparam seg_t SEG_1   = 7'b0110000;
  localparam seg_t SEG_2   = 7'b1101101;
  localparam seg_t SEG_3   = 7'b1111001;
  localparam seg_t SEG_4   = 7'b0110011;
  localparam seg_t SEG_5   = 7'b1011011;
  localparam seg_t SEG_6   = 7'b1011111;
  localparam seg_t SEG_7   = 7'b1110000;
  localparam seg_t SEG_8   = 7'b1111111;
  localparam seg_t SEG_9   = 7'b1111011;
  localparam seg_t SEG_A   = 7'b1110111;
  localparam seg_t SEG_B   = 7'b0011111;
  localparam seg_t SEG_C   = 7'b1001110;
  localparam seg_t SEG_D   = 7'b0111101;
  localparam seg_t SEG_E   = 7'b1001111;
  localparam seg_t SEG_F   = 7'b1000111;
  localparam seg_t SEG_OFF = 7'b0000000;
  localparam seg_t SEG_ALL = 7'b1111111;

  function automatic seg_t apply_polarity(input seg_t lit, input bit active_low);
    return lit ^ {7{active_low}};
  endfunction

endpackage

// File: rtl/bcd_7seg_lut.sv
// rtl/bcd_7seg_lut.sv - combinational 4-bit code to active-high segment pattern
module bcd_7seg_lut
  import bcd_7seg_pkg::*;
#(
  parameter bit HEX_MODE = 1'b0
) (
  input  logic [3:0] code,
  output seg_t       pattern
);

  always_comb begin
    pattern = SEG_OFF;
    case (code)
      4'h0: pattern = SEG_0;
      4'h1: pattern = SEG_1;
      4'h2: pattern = SEG_2;
      4'h3: pattern = SEG_3;
      4'h4: pattern = SEG_4;
      4'h5: pattern = SEG_5;
      4'h6: pattern = SEG_6;
      4'h7: pattern = SEG_7;
      4'h8: pattern = SEG_8;
      4'h9: pattern = SEG_9;
      // Non-BCD codes stay dark unless hex display is wanted
      4'hA: pattern = HEX_MODE ? SEG_A : SEG_OFF;
      4'hB: pattern = HEX_MODE ? SEG_B : SEG_OFF;
      4'hC: pattern = HEX_MODE ? SEG_C : SEG_OFF;
      4'hD: pattern = HEX_MODE ? SEG_D : SEG_OFF;
      4'hE: pattern = HEX_MODE ? SEG_E : SEG_OFF;
      4'hF: pattern = HEX_MODE ? SEG_F : SEG_OFF;
      default: pattern = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/bcd_7seg_decoder.sv
// rtl/bcd_7seg_decoder.sv - registered BCD to seven-segment decoder with lamp test and ripple blanking
module bcd_7seg_decoder
  import bcd_7seg_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1,
  parameter bit HEX_MODE   = 1'b0
) (
  input  logic CLOCK_50,
  input  logic KEY0,
  input  logic A,
  input  logic B,
  input  logic C,
  input  logic D,
  input  logic en,
  input  logic blank,
  input  logic lt,
  input  logic rbi,
  output logic a,
  output logic b,
  output logic c,
  output logic d,
  output logic e,
  output logic f,
  output logic g,
  output logic rbo
);

  logic [3:0] code;
  seg_t       lut_pattern;
  seg_t       lit_next;
  logic       zero_suppress;
  seg_t       seg_q;
  logic       rbo_q;

  assign code = {A, B, C, D};

  bcd_7seg_lut #(
    .HEX_MODE (HEX_MODE)
  ) u_lut (
    .code    (code),
    .pattern (lut_pattern)
  );

  assign zero_suppress = rbi && (code == 4'h0);

  always_comb begin
    lit_next = lut_pattern;
    if (lt)
      lit_next = SEG_ALL;
    else if (blank || zero_suppress)
      lit_next = SEG_OFF;
  end

  // Polarity is folded in before the register so the outputs are glitch-free flops
  always_ff @(posedge CLOCK_50) begin
    if (!KEY0) begin
      seg_q <= apply_polarity(SEG_OFF, ACTIVE_LOW);
      rbo_q <= 1'b0;
    end else if (en) begin
      seg_q <= apply_polarity(lit_next, ACTIVE_LOW);
      rbo_q <= zero_suppress && !lt && !blank;
    end
  end

  assign {a, b, c, d, e, f, g} = seg_q;
  assign rbo = rbo_q;

endmodule

// File: tb/tb_bcd_7seg_decoder.sv
// tb/tb_bcd_7seg_decoder.sv - scoreboard bench for bcd_7seg_decoder, decimal and hex instances
module tb_bcd_7seg_decoder;

  logic CLOCK_50;
  logic KEY0;
  logic A, B, C, D;
  logic en, blank, lt, rbi;
  logic a0, b0, c0, d0, e0, f0, g0, rbo0;
  logic a1, b1, c1, d1, e1, f1, g1, rbo1;

  typedef struct {
    logic [6:0] seg0;
    logic [6:0] seg1;
    logic       rbo;
  } exp_t;

  exp_t       sb[$];
  exp_t       ex;
  logic [6:0] m_lit0, m_lit1;
  logic       m_rbo;
  int         checks = 0;
  int         passed = 0;

  bcd_7seg_decoder #(.ACTIVE_LOW(1'b1), .HEX_MODE(1'b0)) dut_dec (
    .CLOCK_50(CLOCK_50), .KEY0(KEY0), .A(A), .B(B), .C(C), .D(D),
    .en(en), .blank(blank), .lt(lt), .rbi(rbi),
    .a(a0), .b(b0), .c(c0), .d(d0), .e(e0), .f(f0), .g(g0), .rbo(rbo0)
  );

  bcd_7seg_decoder #(.ACTIVE_LOW(1'b1), .HEX_MODE(1'b1)) dut_hex (
    .CLOCK_50(CLOCK_50), .KEY0(KEY0), .A(A), .B(B), .C(C), .D(D),
    .en(en), .blank(blank), .lt(lt), .rbi(rbi),
    .a(a1), .b(b1), .c(c1), .d(d1), .e(e1), .f(f1), .g(g1), .rbo(rbo1)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  function automatic string seg_letters(input logic [3:0] code, input bit hex);
    case (code)
      4'd0: return "abcdef";
      4'd1: return "bc";
      4'd2: return "abdeg";
      4'd3: return "abcdg";
      4'd4: return "bcfg";
      4'd5: return "acdfg";
      4'd6: return "acdefg";
      4'd7: return "abc";
      4'd8: return "abcdefg";
      4'd9: return "abcdfg";
      4'd10: return hex ? "abcefg" : "";
      4'd11: return hex ? "cdefg" : "";
      4'd12: return hex ? "adef" : "";
      4'd13: return hex ? "bcdeg" : "";
      4'd14: return hex ? "adefg" : "";
      default: return hex ? "aefg" : "";
    endcase
  endfunction

  // Lit mask in abcdefg order (bit 6 = a)
  function automatic logic [6:0] letters_to_lit(input string s);
    logic [6:0] r = 7'b0;
    for (int i = 0; i < s.len(); i++)
      r[6 - (s[i] - "a")] = 1'b1;
    return r;
  endfunction

  function automatic logic [7:0] got0();
    return {a0, b0, c0, d0, e0, f0, g0, rbo0};
  endfunction

  function automatic logic [7:0] got1();
    return {a1, b1, c1, d1, e1, f1, g1, rbo1};
  endfunction

  task automatic drive(input logic key, input logic en_i, input logic lt_i,
                       input logic blank_i, input logic rbi_i, input logic [3:0] code);
    KEY0 = key; en = en_i; lt = lt_i; blank = blank_i; rbi = rbi_i;
    {A, B, C, D} = code;
    if (!key) begin
      m_lit0 = 7'b0; m_lit1 = 7'b0; m_rbo = 1'b0;
    end else if (en_i) begin
      if (lt_i) begin
        m_lit0 = 7'h7F; m_lit1 = 7'h7F;
      end else if (blank_i || (rbi_i && code == 4'd0)) begin
        m_lit0 = 7'b0; m_lit1 = 7'b0;
      end else begin
        m_lit0 = letters_to_lit(seg_letters(code, 1'b0));
        m_lit1 = letters_to_lit(seg_letters(code, 1'b1));
      end
      m_rbo = rbi_i && (code == 4'd0) && !lt_i && !blank_i;
    end
    sb.push_back('{~m_lit0, ~m_lit1, m_rbo});
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd8);
      step();
      ex = sb.pop_front();
      checks++;
      if (got0() !== 8'b1111111_0 || got1() !== 8'b1111111_0 || got0() !== {ex.seg0, ex.rbo})
        $display("FAIL reset edge %0d: got %b/%b expected %b", i, got0(), got1(), 8'b1111111_0);
      else passed++;
    end
  endtask

  task automatic test_decode();
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'(k));
      step();
      ex = sb.pop_front();
      checks++;
      if (got0() !== {ex.seg0, ex.rbo} || got1() !== {ex.seg1, ex.rbo})
        $display("FAIL decode code %0d: got %b/%b expected %b/%b", k, got0(), got1(),
                 {ex.seg0, ex.rbo}, {ex.seg1, ex.rbo});
      else passed++;
      if (k == 0 || k == 7) begin
        checks++;
        if ({g0, f0, e0, d0, c0, b0, a0} !== (k == 0 ? 7'b1000000 : 7'b1111000))
          $display("FAIL decode gfedcba code %0d: got %b expected %b", k,
                   {g0, f0, e0, d0, c0, b0, a0}, (k == 0 ? 7'b1000000 : 7'b1111000));
        else passed++;
      end
    end
  endtask

  task automatic test_hex();
    for (int k = 10; k < 16; k++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'(k));
      step();
      ex = sb.pop_front();
      checks++;
      if (got0() !== {ex.seg0, ex.rbo} || got1() !== {ex.seg1, ex.rbo})
        $display("FAIL hex code %0d: got %b/%b expected %b/%b", k, got0(), got1(),
                 {ex.seg0, ex.rbo}, {ex.seg1, ex.rbo});
      else passed++;
      if (k == 12) begin
        checks++;
        if (got0() !== 8'b1111111_0 || got1() !== 8'b0110001_0)
          $display("FAIL hex code 12 abcdefg: got %b/%b expected %b/%b", got0(), got1(),
                   8'b1111111_0, 8'b0110001_0);
        else passed++;
      end
    end
  endtask

  task automatic test_hold();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd5);
    step();
    ex = sb.pop_front();
    checks++;
    if (got0() !== {ex.seg0, ex.rbo}) $display("FAIL hold load 5: got %b expected %b", got0(), {ex.seg0, ex.rbo});
    else passed++;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'(i == 0), 1'(i == 1), 1'(i == 2), (i == 2) ? 4'd0 : 4'd3);
      step();
      ex = sb.pop_front();
      checks++;
      if (got0() !== {ex.seg0, ex.rbo} || got0() !== 8'b0100100_0)
        $display("FAIL hold en=0 cycle %0d: got %b expected %b", i, got0(), 8'b0100100_0);
      else passed++;
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3);
    step();
    ex = sb.pop_front();
    checks++;
    if (got0() !== {ex.seg0, ex.rbo} || got0() !== 8'b0000110_0)
      $display("FAIL hold release 3: got %b expected %b", got0(), 8'b0000110_0);
    else passed++;
  endtask

  task automatic test_ripple_blank();
    logic [7:0] want [4] = '{8'b1111111_1, 8'b1001100_0, 8'b0000000_0, 8'b1111111_0};
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd4);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd8);
    // Stimulus was queued up front; replay it one edge at a time against the scoreboard
    KEY0 = 1'b1; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: begin lt = 0; blank = 0; rbi = 1; {A, B, C, D} = 4'd0; end
        1: begin lt = 0; blank = 0; rbi = 1; {A, B, C, D} = 4'd4; end
        2: begin lt = 1; blank = 1; rbi = 1; {A, B, C, D} = 4'd0; end
        default: begin lt = 0; blank = 1; rbi = 0; {A, B, C, D} = 4'd8; end
      endcase
      step();
      ex = sb.pop_front();
      checks++;
      if (got0() !== {ex.seg0, ex.rbo} || got1() !== want[i])
        $display("FAIL ripple case %0d: got %b/%b expected %b", i, got0(), got1(), want[i]);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 5) == 0),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      step();
      ex = sb.pop_front();
      checks++;
      if (got0() !== {ex.seg0, ex.rbo} || got1() !== {ex.seg1, ex.rbo})
        $display("FAIL random cycle %0d: got %b/%b expected %b/%b", i, got0(), got1(),
                 {ex.seg0, ex.rbo}, {ex.seg1, ex.rbo});
      else passed++;
    end
  endtask

  initial begin
    m_lit0 = 7'b0; m_lit1 = 7'b0; m_rbo = 1'b0;
    KEY0 = 1'b0; en = 1'b0; lt = 1'b0; blank = 1'b0; rbi = 1'b0;
    {A, B, C, D} = 4'd0;
    #1;
    test_reset();
    test_decode();
    test_hex();
    test_hold();
    test_ripple_blank();
    test_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
